// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the switch-driven calculator. The state codes are
// also decoded by the display selector: codes 0 and 2 show the 16-bit switch
// value, code 4 shows the 5-bit op switches, and every other code shows the
// default source. Keep the encoding below fixed.
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_DATA_W = 16;  // operand / switch width
  localparam int CALC_OP_W   = 5;   // operation code width

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_LOAD_A  = 3'd1,
    S_WAIT_B  = 3'd2,
    S_LOAD_B  = 3'd3,
    S_WAIT_OP = 3'd4,
    S_LOAD_OP = 3'd5,
    S_SHOW    = 3'd6
    // 3'd7 is unused; the sequencer recovers to S_WAIT_A from it.
  } calc_state_t;

endpackage

// File: rtl/calc_entry_fsm_edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Rising-edge pulse generator for a debounced, clk-synchronous button level.
// pulse_o is high for the single cycle in which level_i is high and was low
// on the previous cycle. The history register clears on reset, so a level
// that is already high when reset releases produces one pulse.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   level_i  in   button level
//   pulse_o  out  one-cycle rising-edge pulse (combinational)
// -----------------------------------------------------------------------------
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/calc_entry_fsm.sv
// -----------------------------------------------------------------------------
// calc_entry_fsm
// Entry sequencer for the calculator. Successive Enter presses capture
// operand A, operand B and the operation code; the captured values are held
// for the ALU until overwritten by a later entry round.
//
// Each WAIT state advances to its LOAD state on an Enter rising edge. A LOAD
// state lasts one cycle and captures the switches on the clock that leaves it,
// so a captured value appears two clocks after Enter rises.
//
// Optional build macro CALC_UNDO_EN: when defined, an Undo rising edge steps
// back one entry stage (WAIT_B->WAIT_A, WAIT_OP->WAIT_B, SHOW->WAIT_OP) without
// touching captured values; Enter wins if both edges coincide. When undefined
// the undo input is ignored and no undo edge register exists.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   enter         in   debounced Enter level
//   undo          in   debounced Undo level (CALC_UNDO_EN builds only)
//   data_in       in   operand switches [DATA_W]
//   op_in         in   operation switches [OP_W]
//   state         out  current state code (registered, also the FSM debug view)
//   op_a          out  captured operand A
//   op_b          out  captured operand B
//   op_code       out  captured operation
//   result_valid  out  registered, high in every S_SHOW cycle
// -----------------------------------------------------------------------------
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int OP_W   = CALC_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic              undo,
  input  logic [DATA_W-1:0] data_in,
  input  logic [OP_W-1:0]   op_in,
  output logic [2:0]        state,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [OP_W-1:0]   op_code,
  output logic              result_valid
);

  calc_state_t       state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0]   op_code_q, op_code_d;
  logic              result_valid_q, result_valid_d;

  logic enter_edge;
  logic undo_edge;

  edge_det u_enter_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (enter),
    .pulse_o (enter_edge)
  );

`ifdef CALC_UNDO_EN
  edge_det u_undo_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (undo),
    .pulse_o (undo_edge)
  );
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign undo_edge   = 1'b0;
`endif

  // Next state and capture. LOAD states ignore both buttons; a fresh edge
  // cannot arrive there anyway since the level must drop for a cycle first.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    case (state_q)
      S_WAIT_A: begin
        if (enter_edge) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        op_a_d  = data_in;
        state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (enter_edge)     state_d = S_LOAD_B;
        else if (undo_edge) state_d = S_WAIT_A;
      end
      S_LOAD_B: begin
        op_b_d  = data_in;
        state_d = S_WAIT_OP;
      end
      S_WAIT_OP: begin
        if (enter_edge)     state_d = S_LOAD_OP;
        else if (undo_edge) state_d = S_WAIT_B;
      end
      S_LOAD_OP: begin
        op_code_d = op_in;
        state_d   = S_SHOW;
      end
      S_SHOW: begin
        if (enter_edge)     state_d = S_WAIT_A;
        else if (undo_edge) state_d = S_WAIT_OP;
      end
      default: begin
        // Code 7 is not a real state; recover to the start of entry.
        state_d = S_WAIT_A;
      end
    endcase
    result_valid_d = (state_d == S_SHOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_WAIT_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_code_q      <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_code_q      <= op_code_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign state        = state_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_code      = op_code_q;
  assign result_valid = result_valid_q;

endmodule
